// File: rtl/residue_check_scheduler.sv
// Sequencing controller for a mod-(2^MOD_BITS-1) residue checker on the ALU
// add/multiply paths. One descriptor is latched per handshake. A single shared
// residue unit is time-multiplexed over a, b, res_lo and res_hi. The block then
// reports whether the operand residues predict the result residue, and keeps a
// sticky error flag and a saturating mismatch counter.
module residue_check_scheduler #(
  parameter int MOD_BITS  = 5,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_op,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic [31:0]          in_res_lo,
  input  logic [31:0]          in_res_hi,
  output logic                 out_valid,
  output logic                 out_error,
  output logic                 err_flag,
  output logic [CNT_WIDTH-1:0] err_count,
  input  logic                 clear_err
);

  // Working width for folded residue arithmetic: holds chunk sums and the
  // product of two residues with headroom.
  localparam int ACC_W = 2 * MOD_BITS + 8;
  localparam logic [MOD_BITS-1:0] M     = {MOD_BITS{1'b1}};
  localparam logic [ACC_W-1:0]    M_W   = ACC_W'(M);
  // Residue of 2^32: the weight of the high product word and the value lost
  // when an add carries out of bit 31.
  localparam logic [MOD_BITS-1:0] W_RES = MOD_BITS'(1 << (32 % MOD_BITS));

  typedef enum logic [2:0] {
    S_IDLE, S_RES_A, S_RES_B, S_RES_LO, S_RES_HI, S_CHECK
  } state_t;

  // End-around-carry folding; the all-ones value is congruent to zero.
  function automatic logic [MOD_BITS-1:0] mod_m(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] acc;
    acc = v;
    for (int k = 0; k < 8; k++) acc = (acc & M_W) + (acc >> MOD_BITS);
    if (acc == M_W) acc = '0;
    return acc[MOD_BITS-1:0];
  endfunction

  // Residue of a 32-bit word: sum of MOD_BITS-wide chunks, then fold.
  function automatic logic [MOD_BITS-1:0] residue(input logic [31:0] x);
    logic [ACC_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < 32; i += MOD_BITS) sum += ACC_W'((x >> i) & 32'(M));
    return mod_m(sum);
  endfunction

  // Counter increment that holds at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

  state_t                state_q, state_d;
  logic                  op_q;
  logic [31:0]           a_q, b_q, lo_q, hi_q;
  logic [MOD_BITS-1:0]   ra_q, rb_q, rl_q, rh_q;
  logic [31:0]           res_in;
  logic [MOD_BITS-1:0]   res_out;
  logic                  out_valid_q, out_error_q;
  logic                  err_flag_q, err_flag_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic                  err_hit;
  logic [32:0]           sum33;
  logic [MOD_BITS-1:0]   exp_add, exp_mul, obs_mul;
  logic                  mismatch;

  // State register; reset aborts any check in flight.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: fixed walk through the residue states, RES_HI only for multiply.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_RES_A;
      S_RES_A:  state_d = S_RES_B;
      S_RES_B:  state_d = S_RES_LO;
      S_RES_LO: state_d = op_q ? S_RES_HI : S_CHECK;
      S_RES_HI: state_d = S_CHECK;
      S_CHECK:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs: handshake and the shared residue unit's input mux.
  always_comb begin
    in_ready = (state_q == S_IDLE);
    res_in   = a_q;
    case (state_q)
      S_RES_B:  res_in = b_q;
      S_RES_LO: res_in = lo_q;
      S_RES_HI: res_in = hi_q;
      default:  res_in = a_q;
    endcase
  end

  assign res_out = residue(res_in);

  // Descriptor capture on accept and residue capture, one word per state.
  always_ff @(posedge clock) begin
    if (state_q == S_IDLE && in_valid) begin
      op_q <= in_op;
      a_q  <= in_a;
      b_q  <= in_b;
      lo_q <= in_res_lo;
      hi_q <= in_res_hi;
    end
    if (state_q == S_RES_A)  ra_q <= res_out;
    if (state_q == S_RES_B)  rb_q <= res_out;
    if (state_q == S_RES_LO) rl_q <= res_out;
    if (state_q == S_RES_HI) rh_q <= res_out;
  end

  // Compare predicted and observed residues; a carry-out of the add removes 2^32.
  always_comb begin
    sum33    = {1'b0, a_q} + {1'b0, b_q};
    exp_add  = mod_m(ACC_W'(ra_q) + ACC_W'(rb_q) +
                     (sum33[32] ? ACC_W'(M - W_RES) : '0));
    exp_mul  = mod_m(ACC_W'(ra_q) * ACC_W'(rb_q));
    obs_mul  = mod_m(ACC_W'(rh_q) * ACC_W'(W_RES) + ACC_W'(rl_q));
    mismatch = op_q ? (exp_mul != obs_mul) : (exp_add != rl_q);
  end

  // Registered one-cycle report leaving CHECK.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_error_q <= 1'b0;
    end else begin
      out_valid_q <= (state_q == S_CHECK);
      out_error_q <= (state_q == S_CHECK) && mismatch;
    end
  end

  // Status update: clear first, then count the reported mismatch.
  always_comb begin
    err_hit     = out_valid_q & out_error_q;
    err_flag_d  = (err_flag_q & ~clear_err) | err_hit;
    err_count_d = clear_err ? '0 : err_count_q;
    if (err_hit) err_count_d = sat_inc(err_count_d);
  end

  // Sticky flag and saturating counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_error = out_error_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_residue_check_scheduler.sv
// Bench for residue_check_scheduler: directed cases from the check list plus
// random traffic, all compared every cycle against a transaction-level model
// (latency countdown + plain 64-bit modular arithmetic).
module tb_residue_check_scheduler;

  localparam int MB = 5;
  localparam int CW = 2;
  localparam longint unsigned M = 31;
  localparam int unsigned CMAX = 3;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_op;
  logic [31:0]   in_a, in_b, in_res_lo, in_res_hi;
  logic          out_valid, out_error, err_flag;
  logic [CW-1:0] err_count;
  logic          clear_err;

  residue_check_scheduler #(.MOD_BITS(MB), .CNT_WIDTH(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_res_lo (in_res_lo),
    .in_res_hi (in_res_hi),
    .out_valid (out_valid),
    .out_error (out_error),
    .err_flag  (err_flag),
    .err_count (err_count),
    .clear_err (clear_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Does the reported result disagree with the operands modulo M?
  function automatic bit model_mismatch(input bit op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] lo, input logic [31:0] hi);
    longint unsigned s, p, r;
    if (!op) begin
      s = (64'(a) + 64'(b)) & 64'hFFFF_FFFF;
      return (s % M) != (64'(lo) % M);
    end
    p = 64'(a) * 64'(b);
    r = {hi, lo};
    return (p % M) != (r % M);
  endfunction

  // Transaction-level model state
  bit          m_active = 0;
  bit          m_busy, m_valid, m_err, m_pend, m_flag;
  int          m_cnt;
  int unsigned m_count;

  always @(posedge clock) begin
    bit was_busy, hit;
    if (!reset) begin
      m_active = 1; m_busy = 0; m_cnt = 0; m_valid = 0; m_err = 0;
      m_flag = 0; m_count = 0; m_pend = 0;
    end else begin
      hit = m_valid && m_err;
      if (clear_err) begin m_flag = 0; m_count = 0; end
      if (hit) begin
        m_flag = 1;
        if (m_count != CMAX) m_count++;
      end
      was_busy = m_busy;
      m_valid = 0; m_err = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin m_valid = 1; m_err = m_pend; m_busy = 0; end
      end
      if (!was_busy && in_valid) begin
        m_busy = 1;
        m_cnt  = in_op ? 5 : 4;
        m_pend = model_mismatch(in_op, in_a, in_b, in_res_lo, in_res_hi);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (m_active) begin
      check("in_ready",  in_ready,  !m_busy);
      check("out_valid", out_valid, m_valid);
      check("out_error", out_error, m_err);
      check("err_flag",  err_flag,  m_flag);
      check("err_count", err_count, m_count);
    end
  end

  // Issue one descriptor, wait for its report, check latency and verdict.
  // Entered and left 1 time unit after a rising edge.
  task automatic send(input bit op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] lo, input logic [31:0] hi,
                      input int exp_lat, input bit exp_err, input string name, input bit clr);
    int t, lat;
    bit seen;
    t = 0;
    while (!in_ready && t < 50) begin @(posedge clock); #1; t++; end
    check({name, " ready_wait"}, (t < 50), 1);
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_res_lo = lo; in_res_hi = hi;
    @(posedge clock); #1;
    in_valid = 0;
    seen = 0; lat = 0;
    while (!seen && lat < 12) begin
      @(posedge clock); @(negedge clock);
      lat++;
      seen = out_valid;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " out_error"}, out_error, exp_err);
    if (clr) clear_err = 1;
    @(posedge clock); #1;
    clear_err = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, lat;
    logic [63:0] p;
    logic [31:0] a, b, lo, hi;
    bit op;
    reset = 0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0;
    in_res_lo = 0; in_res_hi = 0; clear_err = 0;

    // Model pins: hand-computed verdicts
    check("model add_pass",  model_mismatch(0, 100, 200, 300, 0), 0);
    check("model add_fault", model_mismatch(0, 100, 200, 301, 0), 1);
    check("model add_alias", model_mismatch(0, 100, 200, 331, 0), 0);
    check("model mul_pass",  model_mismatch(1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 1), 0);
    check("model mul_fault", model_mismatch(1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 0), 1);
    check("model add_wrap",  model_mismatch(0, 32'hFFFF_FFFF, 1, 0, 0), 0);

    repeat (2) @(posedge clock);
    #1 reset = 1;
    @(negedge clock);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset err_flag", err_flag, 0);
    check("reset err_count", err_count, 0);
    @(posedge clock); #1;

    send(0, 100, 200, 300, 0, 4, 0, "add_pass", 0);
    check("add_pass err_flag", err_flag, 0);
    send(0, 100, 200, 301, 0, 4, 1, "add_fault", 0);
    check("add_fault err_flag", err_flag, 1);
    check("add_fault err_count", err_count, 1);
    send(0, 100, 200, 331, 0, 4, 0, "add_alias", 0);
    check("add_alias err_count", err_count, 1);
    send(1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 1, 5, 0, "mul_pass", 0);
    send(1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 0, 5, 1, "mul_fault", 0);
    check("mul_fault err_count", err_count, 2);
    send(0, 32'hFFFF_FFFF, 1, 0, 0, 4, 0, "add_wrap", 0);

    // in_valid held high through a multiply: one report, re-accept on its cycle
    in_valid = 1; in_op = 1; in_a = 32'hFFFF_FFFF; in_b = 2;
    in_res_lo = 32'hFFFF_FFFE; in_res_hi = 1;
    @(posedge clock); #1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); @(negedge clock);
      if (out_valid) pulses++;
    end
    check("hold pulses", pulses, 1);
    check("hold second accept", in_ready, 0);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 12) begin @(posedge clock); @(negedge clock); lat++; end
    check("hold second latency", lat, 5);
    @(posedge clock); #1;

    // Reset in the middle of a check
    in_valid = 1; in_op = 0; in_a = 100; in_b = 200; in_res_lo = 301; in_res_hi = 0;
    @(posedge clock); #1 in_valid = 0;
    @(posedge clock); #1 reset = 0;
    @(posedge clock); #1 reset = 1;
    @(negedge clock);
    check("midreset in_ready", in_ready, 1);
    check("midreset out_error", out_error, 0);
    check("midreset err_flag", err_flag, 0);
    check("midreset err_count", err_count, 0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (out_valid) pulses++;
    end
    check("midreset pulses", pulses, 0);
    @(posedge clock); #1;

    // Saturation of the 2-bit counter, then clear coincident with a fault
    for (int i = 0; i < 5; i++)
      send(0, 32'(i * 11), 7, 32'(i * 11 + 8), 0, 4, 1, "sat_fault", 0);
    check("sat err_count", err_count, 3);
    check("sat err_flag", err_flag, 1);
    send(0, 50, 7, 58, 0, 4, 1, "clr_fault", 1);
    check("clr+fault err_count", err_count, 1);
    check("clr+fault err_flag", err_flag, 1);
    clear_err = 1;
    @(posedge clock); #1 clear_err = 0;
    check("clear err_count", err_count, 0);
    check("clear err_flag", err_flag, 0);

    // Random traffic, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      op = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      if (op) p = 64'(a) * 64'(b);
      else    p = {$urandom, a + b};
      case ($urandom_range(0, 3))
        2: p = op ? p + 64'(31 * $urandom_range(1, 100))
                  : {p[63:32], p[31:0] + 32'(31 * $urandom_range(1, 100))};
        3: p = p ^ (64'd1 << $urandom_range(0, op ? 63 : 31));
        default: ;
      endcase
      {hi, lo} = p;
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = op; in_a = a; in_b = b; in_res_lo = lo; in_res_hi = hi;
      clear_err = ($urandom_range(0, 31) == 0);
      reset     = !($urandom_range(0, 499) == 0);
      @(posedge clock); #1;
    end
    in_valid = 0; clear_err = 0; reset = 1;
    repeat (8) @(posedge clock);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
